// File: rtl/sa_ctrl_pkg.sv
// Shared types, default widths and operand/result packing helpers for the 2x2 systolic job controller.
package sa_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 4;
  localparam int unsigned DEF_ACC_WIDTH      = 9;
  localparam int unsigned DEF_FEED_CYCLES    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
  localparam int unsigned DEF_CNT_WIDTH      = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    RESP
  } state_e;

  function automatic logic [4*DEF_DATA_WIDTH-1:0] pack_op(
    input logic [DEF_DATA_WIDTH-1:0] e00,
    input logic [DEF_DATA_WIDTH-1:0] e01,
    input logic [DEF_DATA_WIDTH-1:0] e10,
    input logic [DEF_DATA_WIDTH-1:0] e11
  );
    return {e11, e10, e01, e00};
  endfunction

  function automatic logic [DEF_ACC_WIDTH-1:0] unpack_res(
    input logic [4*DEF_ACC_WIDTH-1:0] c,
    input int unsigned                idx
  );
    return c[idx*DEF_ACC_WIDTH +: DEF_ACC_WIDTH];
  endfunction

  // Counter width able to hold the larger of the two load values.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sa_ctrl_timer.sv
// Loadable down-counter with a zero flag; shared by the FEED window and the drain watchdog.
module sa_ctrl_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sa2x2_job_ctrl.sv
// Job sequencer for the 2x2 systolic array: accept A/B, clear, feed, drain, present C.
// Optional drain watchdog enabled by defining SA_CTRL_TIMEOUT_EN.
module sa2x2_job_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int unsigned FEED_CYCLES    = DEF_FEED_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [4*DATA_WIDTH-1:0] job_a,
  input  logic [4*DATA_WIDTH-1:0] job_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [4*ACC_WIDTH-1:0]  res_c,
  output logic                    res_err,
  output logic                    sa_clr_n,
  output logic                    sa_in_valid,
  output logic [4*DATA_WIDTH-1:0] sa_a,
  output logic [4*DATA_WIDTH-1:0] sa_b,
  input  logic                    sa_out_valid,
  input  logic [4*ACC_WIDTH-1:0]  sa_c,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    job_count
);

  localparam int unsigned TW = timer_width(FEED_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] FEED_LOAD = TW'(FEED_CYCLES - 1);

  state_e          state, state_nx;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic            capture;

  sa_ctrl_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

`ifdef SA_CTRL_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  logic timeout;
  logic res_err_q;
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    capture  = 1'b0;
`ifdef SA_CTRL_TIMEOUT_EN
    timeout  = 1'b0;
`endif
    case (state)
      IDLE:  if (job_valid && job_ready) state_nx = CLEAR;
      CLEAR: begin
        state_nx = FEED;
        tmr_load = 1'b1;
        tmr_val  = FEED_LOAD;
      end
      FEED: begin
        if (tmr_zero) begin
          state_nx = DRAIN;
`ifdef SA_CTRL_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TO_LOAD;
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DRAIN: begin
        if (sa_out_valid) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
`ifdef SA_CTRL_TIMEOUT_EN
        else if (tmr_zero) begin
          timeout  = 1'b1;
          state_nx = RESP;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      RESP:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      job_ready   <= 1'b0;
      busy        <= 1'b0;
      sa_clr_n    <= 1'b1;
      sa_in_valid <= 1'b0;
      res_valid   <= 1'b0;
      sa_a        <= '0;
      sa_b        <= '0;
      res_c       <= '0;
      job_count   <= '0;
`ifdef SA_CTRL_TIMEOUT_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      job_ready   <= (state_nx == IDLE);
      busy        <= (state_nx != IDLE);
      sa_clr_n    <= (state_nx != CLEAR);
      sa_in_valid <= (state_nx == FEED);
      res_valid   <= (state_nx == RESP);
      if ((state == IDLE) && job_valid && job_ready) begin
        sa_a <= job_a;
        sa_b <= job_b;
      end
      if (capture) begin
        res_c <= sa_c;
`ifdef SA_CTRL_TIMEOUT_EN
        res_err_q <= 1'b0;
`endif
      end
`ifdef SA_CTRL_TIMEOUT_EN
      if (timeout) begin
        res_c     <= '0;
        res_err_q <= 1'b1;
      end
`endif
      if ((state == RESP) && res_ready) job_count <= job_count + CNT_WIDTH'(1);
    end
  end

endmodule
